// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults, read-mode constants and depth helper for the UART FIFO
package uart_fifo_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 11;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port distributed RAM, synchronous write, asynchronous read
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    (* ram_style = "distributed" *) logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // storage is not reset; only the pointers define valid contents
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with level, thresholds, flush, sticky errors and optional FWFT
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = fifo_depth(ADDR_W) - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int            DEPTH   = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_AF    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] L_AE    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("uart_sync_fifo: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("uart_sync_fifo: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
    end

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_dout;
    logic              r_ovf;
    logic              r_unf;
    logic              w_wr_stb;
    logic              w_rd_stb;
    logic [DATA_W-1:0] w_rdata;

    assign full         = r_level == L_DEPTH;
    assign empty        = r_level == '0;
    assign almost_full  = r_level >= L_AF;
    assign almost_empty = r_level <= L_AE;
    assign level        = r_level;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

    assign w_wr_stb = wr_en & ~full;
    assign w_rd_stb = rd_en & ~empty;

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_stb & ~flush),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // pointers and fill level; flush overrides any accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_stb) r_wr_ptr <= r_wr_ptr + L_ONE;
            if (w_rd_stb) r_rd_ptr <= r_rd_ptr + L_ONE;
            if (w_wr_stb && !w_rd_stb) r_level <= r_level + L_ONE;
            else if (w_rd_stb && !w_wr_stb) r_level <= r_level - L_ONE;
        end
    end

    // registered read data for standard mode, held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dout <= '0;
        else if (flush) r_dout <= '0;
        else if (w_rd_stb) r_dout <= w_rdata;
    end

    // sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~clr_err) | (wr_en & full & ~flush);
            r_unf <= (r_unf & ~clr_err) | (rd_en & empty & ~flush);
        end
    end

    assign dout = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : w_rdata) : r_dout;

    // level must always equal the pointer distance
    a_level_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        r_level == r_wr_ptr - r_rd_ptr);

endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: table vectors plus queue scoreboard over standard and FWFT instances
module tb_uart_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       clr_err;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] s_level, f_level;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         lvl;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    uart_sync_fifo #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .din(din),
        .wr_en(wr_en), .rd_en(rd_en), .dout(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
        .overflow(s_ovf), .underflow(s_unf)
    );

    uart_sync_fifo #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .din(din),
        .wr_en(wr_en), .rd_en(rd_en), .dout(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_unf)
    );

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input int l,
                                input logic f, input logic e, input logic af, input logic ae,
                                input logic o, input logic [7:0] dq);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.lvl = l; v.full = f; v.empty = e;
        v.af = af; v.ae = ae; v.ovf = o; v.dout = dq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"}, s_level, n);
        chk({tag, ".full"}, s_full, n == 8);
        chk({tag, ".empty"}, s_empty, n == 0);
        chk({tag, ".almost_full"}, s_af, n >= 6);
        chk({tag, ".almost_empty"}, s_ae, n <= 1);
        chk({tag, ".overflow"}, s_ovf, m_ovf);
        chk({tag, ".underflow"}, s_unf, m_unf);
        chk({tag, ".dout_std"}, s_dout, m_dout);
        chk({tag, ".dout_fwft"}, f_dout, n > 0 ? q[0] : 8'h00);
        chk({tag, ".level_fwft"}, f_level, n);
        chk({tag, ".flags_fwft"}, {f_full, f_empty, f_af, f_ae, f_ovf, f_unf},
            {n == 8, n == 0, n >= 6, n <= 1, m_ovf, m_unf});
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d,
                        input logic fl, input logic ce);
        logic mf, me;
        @(negedge clk);
        wr_en = w; rd_en = r; din = d; flush = fl; clr_err = ce;
        @(posedge clk);
        mf = q.size() == 8;
        me = q.size() == 0;
        m_ovf = (m_ovf & ~ce) | (w & mf & ~fl);
        m_unf = (m_unf & ~ce) | (r & me & ~fl);
        if (fl) begin
            q.delete();
            m_dout = 8'h00;
        end else begin
            if (r && !me) m_dout = q.pop_front();
            if (w && !mf) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00);
        tbl[1]  = mk(1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 8'h00);
        tbl[2]  = mk(1, 0, 8'h12, 2, 0, 0, 0, 0, 0, 8'h00);
        tbl[3]  = mk(1, 0, 8'h13, 3, 0, 0, 0, 0, 0, 8'h00);
        tbl[4]  = mk(1, 0, 8'h14, 4, 0, 0, 0, 0, 0, 8'h00);
        tbl[5]  = mk(1, 0, 8'h15, 5, 0, 0, 0, 0, 0, 8'h00);
        tbl[6]  = mk(1, 0, 8'h16, 6, 0, 0, 1, 0, 0, 8'h00);
        tbl[7]  = mk(1, 0, 8'h17, 7, 0, 0, 1, 0, 0, 8'h00);
        tbl[8]  = mk(1, 0, 8'h18, 8, 1, 0, 1, 0, 0, 8'h00);
        tbl[9]  = mk(1, 0, 8'h99, 8, 1, 0, 1, 0, 1, 8'h00);
        tbl[10] = mk(0, 1, 8'h00, 7, 0, 0, 1, 0, 1, 8'h11);
        tbl[11] = mk(0, 1, 8'h00, 6, 0, 0, 1, 0, 1, 8'h12);
        tbl[12] = mk(0, 1, 8'h00, 5, 0, 0, 0, 0, 1, 8'h13);
        tbl[13] = mk(0, 1, 8'h00, 4, 0, 0, 0, 0, 1, 8'h14);
        tbl[14] = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 8'h15);
        tbl[15] = mk(0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 8'h16);
        tbl[16] = mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h17);
        tbl[17] = mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h18);

        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step("vec", tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0, 1'b0);
            chk("tbl.level", s_level, tbl[i].lvl);
            chk("tbl.flags", {s_full, s_empty, s_af, s_ae, s_ovf},
                {tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae, tbl[i].ovf});
            chk("tbl.dout", s_dout, tbl[i].dout);
        end

        step("clr_ovf", 0, 0, 8'h00, 0, 1);
        chk("clr_ovf.overflow", s_ovf, 0);
        for (int i = 0; i < 8; i++) step("fill", 1, 0, 8'h21 + 8'(i), 0, 0);
        step("full_wr_rd", 1, 1, 8'hEE, 0, 0);
        chk("full_wr_rd.level", s_level, 7);
        chk("full_wr_rd.full", s_full, 0);
        chk("full_wr_rd.dout", s_dout, 8'h21);
        chk("full_wr_rd.overflow", s_ovf, 1);
        for (int i = 0; i < 7; i++) step("drain", 0, 1, 8'h00, 0, 0);
        chk("drain.last", s_dout, 8'h28);

        step("clr_err", 0, 0, 8'h00, 0, 1);
        step("empty_wr_rd", 1, 1, 8'hA5, 0, 0);
        chk("empty_wr_rd.level", s_level, 1);
        chk("empty_wr_rd.underflow", s_unf, 1);
        chk("empty_wr_rd.fwft_dout", f_dout, 8'hA5);
        step("fwft_hold", 0, 0, 8'h00, 0, 0);
        chk("fwft_hold.dout", f_dout, 8'hA5);
        step("pop_a5", 0, 1, 8'h00, 0, 0);
        chk("pop_a5.dout", s_dout, 8'hA5);

        for (int i = 0; i < 20; i++) begin
            step("wrap", 1, i > 0, 8'h40 + 8'(i), 0, 0);
            chk("wrap.level_le2", s_level <= 4'd2, 1);
        end
        step("wrap_end", 0, 1, 8'h00, 0, 0);
        chk("wrap_end.dout", s_dout, 8'h53);

        for (int i = 0; i < 5; i++) step("load5", 1, 0, 8'h51 + 8'(i), 0, 0);
        step("flush", 1, 0, 8'h77, 1, 0);
        chk("flush.level", s_level, 0);
        chk("flush.empty", s_empty, 1);
        chk("flush.dout_std", s_dout, 0);
        chk("flush.dout_fwft", f_dout, 0);
        step("clr_vs_unf", 0, 1, 8'h00, 0, 1);
        chk("clr_vs_unf.underflow", s_unf, 1);

        for (int i = 0; i < 3; i++) step("preload", 1, 0, 8'hC0 + 8'(i), 0, 0);
        step("pre_rst", 0, 1, 8'h00, 0, 0);
        step("idle", 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dout = 8'h00;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_wr", 1, 0, 8'h3C, 0, 0);
        step("post_rst_rd", 0, 1, 8'h00, 0, 0);
        chk("post_rst.dout", s_dout, 8'h3C);
        step("final_idle", 0, 0, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_sync_fifo.md
Name: uart_sync_fifo

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer for UART TX/RX paths where producer and consumer share one clock domain.
- Adds almost-full/almost-empty thresholds, a fill-level count, synchronous flush, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the UART byte engines and the bus-side register interface.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 11, address width; DEPTH = 2**ADDR_W words
AF_THRESH, 2**ADDR_W - 4, almost_full asserts when level >= AF_THRESH (legal 1..DEPTH)
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (legal 0..DEPTH-1)
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of FIFO contents
clr_err  in  1  synchronous clear of overflow/underflow
din  in  DATA_W  write data
wr_en  in  1  write request
rd_en  in  1  read request (standard) / head-word acknowledge (FWFT)
dout  out  DATA_W  read data
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_W+1  words currently stored, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - wr_ptr, rd_ptr and level = 0; dout = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - RAM contents are not reset.
- Pointers are ADDR_W+1 bits; the RAM address is [ADDR_W-1:0]; the MSB distinguishes full from empty on wrap. Pointers wrap naturally modulo 2**(ADDR_W+1).
- Accept strobes: wr_stb = wr_en & ~full; rd_stb = rd_en & ~empty. Both use the registered flags at the current edge.
- level update:
  - +1 on wr_stb only; -1 on rd_stb only; unchanged when both or neither.
  - Saturation is impossible by construction.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered level only.
  - No combinational path from inputs to outputs, except FWFT dout from RAM.
- Simultaneous wr_en & rd_en:
  - When full: the read is accepted, the write is rejected and overflow is set; level drops to DEPTH-1.
  - When empty: the write is accepted, the read is rejected and underflow is set; level rises to 1.
  - Otherwise both are accepted and level is unchanged.
- Standard mode (FWFT=0):
  - rd_stb at edge N loads dout with ram[rd_addr] at edge N (valid in cycle N+1).
  - dout holds its value when there is no read.
  - Write-to-read latency is 2 edges: the write is stored at N, empty drops after N, the read is issued in cycle N+1 and data is out after N+1.
- FWFT mode (FWFT=1):
  - dout = ram[rd_addr] whenever ~empty, and 0 when empty.
  - A word written into an empty FIFO at edge N appears on dout in cycle N+1.
  - rd_en pops the head word; the next word (if any) is shown in the following cycle.
- overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - clr_err clears both.
  - A set event in the same cycle as clr_err wins (the flag stays 1).
- flush:
  - Zeroes wr_ptr, rd_ptr and level, and has priority over wr_en/rd_en in the same cycle (both ignored; no error flags raised).
  - dout is forced to 0.
  - overflow and underflow are unaffected.
- Reset mid-operation: all state returns to reset values immediately. Words in flight are discarded.
- A simulation-time parameter check flags illegal AF_THRESH/AE_THRESH values.

Decomposition:
- Shared package/header uart_fifo_pkg:
  - Default DATA_W and ADDR_W.
  - Read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - DEPTH derivation macro/function.
- One sub-module, uart_fifo_ram:
  - Simple dual-port distributed RAM with synchronous write.
  - Asynchronous read port, so the top level can build both the registered (standard) and fall-through (FWFT) dout.
  - Carries the distributed ram_style attribute.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=3 (DEPTH=8), AF_THRESH=6, AE_THRESH=1.
- Reset then idle -> empty=1, almost_empty=1, full=0, level=0, dout=0, overflow=underflow=0.
- FWFT=0: write 0x11..0x18 on 8 consecutive cycles, then 1 extra write of 0x99.
  - full=1 and level=8; almost_full asserts when level reaches 6; overflow=1.
  - Reading 8 words returns 0x11..0x18 in order, each one cycle after rd_en; the final empty=1.
- Full FIFO with wr_en=rd_en=1 for one cycle -> level=7, full=0, head read, overflow=1, written word discarded.
- Empty FIFO with wr_en=rd_en=1 (0xA5) -> level=1, underflow=1. FWFT=1: dout=0xA5 in the next cycle with no rd_en.
- Wrap: 20 interleaved write/read pairs with an incrementing pattern -> no data loss, order preserved across the pointer MSB toggle, level never exceeds 2.
- Load 5 words; flush together with wr_en=1 -> level=0, empty=1, dout=0, write ignored. Then clr_err with rd_en on empty -> underflow stays 1.
